// File: rtl/jt12_regwr.sv
// CPU-side write front end for the FM register file: address latch, data-write
// FIFO, and a decoder that holds each update strobe for one full slot rotation.
module jt12_regwr #(
  parameter int num_ch  = 6,
  parameter int fifo_aw = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  input  logic       write,
  output logic       busy,
  output logic       ovf,
  output logic [7:0] dout,
  output logic [2:0] ch,
  output logic [1:0] op,
  output logic [5:0] latch_fnum,
  output logic       up_keyon,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks_ar,
  output logic       up_amen_dr,
  output logic       up_sr,
  output logic       up_sl_rr,
  output logic       up_ssgeg,
  output logic       up_fnumlo,
  output logic       up_alg,
  output logic       up_pms
);
  localparam int depth = 1 << fifo_aw;
  localparam logic [4:0] hold_last = 5'(num_ch * 4 - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
  state_t state_reg, state_next;

  logic [7:0]       areg_reg;
  logic             apart_reg;
  logic [16:0]      mem [depth];
  logic [fifo_aw:0] wr_ptr_reg, rd_ptr_reg;
  logic [16:0]      entry_reg;
  logic [4:0]       cnt_reg;
  logic [10:0]      up_reg, dec_up;
  logic             dec_fnum;
  logic             empty, full, pop, push;
  logic [7:0]       e_reg;
  logic             e_part;

  assign empty = wr_ptr_reg == rd_ptr_reg;
  assign full  = (wr_ptr_reg[fifo_aw] != rd_ptr_reg[fifo_aw]) &&
                 (wr_ptr_reg[fifo_aw-1:0] == rd_ptr_reg[fifo_aw-1:0]);
  assign pop   = clk_en && (state_reg == IDLE) && !empty;
  // A pop in the same clk frees the slot, so a full FIFO still takes the push.
  assign push  = write && addr[0] && (!full || pop);
  assign busy  = !empty || (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      areg_reg   <= 8'h00;
      apart_reg  <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf        <= 1'b0;
    end else begin
      if (write && !addr[0]) begin
        areg_reg  <= din;
        apart_reg <= (num_ch == 3) ? 1'b0 : addr[1];
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (write && addr[0] && !push) ovf <= 1'b1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[fifo_aw-1:0]] <= {apart_reg, areg_reg, din};
    if (pop)  entry_reg <= mem[rd_ptr_reg[fifo_aw-1:0]];
  end

  assign e_part = entry_reg[16];
  assign e_reg  = entry_reg[15:8];

  // dec_up bit order: keyon, dt1, tl, ks_ar, amen_dr, sr, sl_rr, ssgeg, fnumlo, alg, pms
  always_comb begin
    dec_up   = '0;
    dec_fnum = 1'b0;
    if (e_reg == 8'h28) begin
      dec_up[0] = !e_part;
    end else if (e_reg[1:0] != 2'd3) begin
      case (e_reg[7:4])
        4'h3: dec_up[1] = 1'b1;
        4'h4: dec_up[2] = 1'b1;
        4'h5: dec_up[3] = 1'b1;
        4'h6: dec_up[4] = 1'b1;
        4'h7: dec_up[5] = 1'b1;
        4'h8: dec_up[6] = 1'b1;
        4'h9: dec_up[7] = 1'b1;
        4'hA: begin
          if (e_reg[3:2] == 2'd0) dec_up[8] = 1'b1;
          else if (e_reg[3:2] == 2'd1) dec_fnum = 1'b1;
        end
        4'hB: begin
          if (e_reg[3:2] == 2'd0) dec_up[9] = 1'b1;
          else if (e_reg[3:2] == 2'd1) dec_up[10] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clk_en) begin
      case (state_reg)
        IDLE:    if (!empty) state_next = LOAD;
        LOAD:    state_next = (dec_up != '0) ? HOLD : IDLE;
        HOLD:    if (cnt_reg == 5'd0) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= 8'h00;
      ch         <= 3'd0;
      op         <= 2'd0;
      latch_fnum <= 6'd0;
      up_reg     <= '0;
      cnt_reg    <= 5'd0;
    end else if (clk_en) begin
      case (state_reg)
        LOAD: begin
          dout    <= entry_reg[7:0];
          ch      <= {e_part, e_reg[1:0]};
          op      <= e_reg[3:2];
          up_reg  <= dec_up;
          cnt_reg <= hold_last;
          if (dec_fnum) latch_fnum <= entry_reg[5:0];
        end
        HOLD: begin
          if (cnt_reg == 5'd0) up_reg <= '0;
          else                 cnt_reg <= cnt_reg - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign {up_pms, up_alg, up_fnumlo, up_ssgeg, up_sl_rr, up_sr,
          up_amen_dr, up_ks_ar, up_tl, up_dt1, up_keyon} = up_reg;
endmodule
